// File: rtl/long_divider.sv
// long_divider: unsigned 2W-by-W restoring divider with divide-by-zero and overflow flags.
// Default build: one result register (latency 1). `define DIVIDER_PIPELINE_EN: one register per step (latency WIDTH+1).
module long_divider #(
   parameter int WIDTH = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               error_divide_by_zero,
   output logic               overflow
);

   // State carried between division steps. The low dividend half is kept intact and indexed
   // by step number, so it is still available as the divide-by-zero remainder at the end.
   typedef struct packed {
      logic             vld;
      logic             ovf;
      logic [WIDTH-1:0] rem;
      logic [WIDTH-1:0] quo;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] div;
   } stage_t;

   // One restoring step. Whenever the incoming remainder is below the divisor, the new
   // remainder is below the divisor too, so WIDTH bits are enough to hold it.
   function automatic stage_t div_step(input stage_t s, input int step);
      stage_t           n;
      logic [WIDTH-1:0] bit_mask;
      logic             lo_bit;
      logic [WIDTH:0]   shifted;
      logic [WIDTH-1:0] diff;
      n        = s;
      bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH - 1 - step);
      lo_bit   = |(s.lo & bit_mask);
      shifted  = {s.rem, lo_bit};
      diff     = shifted[WIDTH-1:0] - s.div;
      if (shifted >= {1'b0, s.div}) begin
         n.rem = diff;
         n.quo = {s.quo[WIDTH-2:0], 1'b1};
      end else begin
         n.rem = shifted[WIDTH-1:0];
         n.quo = {s.quo[WIDTH-2:0], 1'b0};
      end
      return n;
   endfunction

   stage_t in_stage;
   stage_t fin_stage;

   always_comb begin
      in_stage     = '0;
      in_stage.vld = 1'b1;
      in_stage.ovf = (divisor != '0) && (dividend[2*WIDTH-1:WIDTH] >= divisor);
      in_stage.rem = dividend[2*WIDTH-1:WIDTH];
      in_stage.lo  = dividend[WIDTH-1:0];
      in_stage.div = divisor;
   end

`ifdef DIVIDER_PIPELINE_EN
   stage_t stg [WIDTH+1];

   assign stg[0] = in_stage;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_step
      stage_t step_d;
      stage_t step_q;

      always_comb begin
         step_d = div_step(stg[gi], gi);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            step_q <= '0;
         end else begin
            step_q <= step_d;
         end
      end

      assign stg[gi+1] = step_q;
   end

   assign fin_stage = stg[WIDTH];
`else
   always_comb begin
      fin_stage = in_stage;
      for (int i = 0; i < WIDTH; i++) begin
         fin_stage = div_step(fin_stage, i);
      end
   end
`endif

   logic [WIDTH-1:0] quotient_d;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_d;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_d;
   logic             dbz_q;
   logic             ovf_d;
   logic             ovf_q;

   // An empty (reset) stage has vld=0 and all other fields zero, so it formats to all-zero outputs.
   always_comb begin
      quotient_d  = fin_stage.quo;
      remainder_d = fin_stage.rem;
      dbz_d       = fin_stage.vld && (fin_stage.div == '0);
      ovf_d       = fin_stage.ovf;
      if (dbz_d) begin
         quotient_d  = '1;
         remainder_d = fin_stage.lo;
         ovf_d       = 1'b0;
      end else if (ovf_d) begin
         quotient_d  = '1;
         remainder_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
      end
   end

   assign quotient             = quotient_q;
   assign remainder            = remainder_q;
   assign error_divide_by_zero = dbz_q;
   assign overflow             = ovf_q;

endmodule

// File: tb/tb_long_divider.sv
// tb_long_divider: directed vectors, exhaustive back-to-back sweep with an arithmetic model,
// asynchronous reset at start and mid-sweep. Latency follows DIVIDER_PIPELINE_EN.
module tb_long_divider;
   localparam int WIDTH = 5;
`ifdef DIVIDER_PIPELINE_EN
   localparam int LAT = WIDTH + 1;
`else
   localparam int LAT = 1;
`endif
   localparam int MAXQ = (1 << WIDTH) - 1;
   localparam int RW   = 2 * WIDTH + 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [2*WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0]   divisor = '0;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic               error_divide_by_zero;
   logic               overflow;

   typedef struct {
      int          due;
      string       tag;
      int          n;
      int          d;
      logic [RW-1:0] res;
   } exp_t;

   exp_t pend[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   idle_zero = 1'b1;

   long_divider #(.WIDTH(WIDTH)) dut (
      .clk                  (clk),
      .reset                (reset),
      .dividend             (dividend),
      .divisor              (divisor),
      .quotient             (quotient),
      .remainder            (remainder),
      .error_divide_by_zero (error_divide_by_zero),
      .overflow             (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [RW-1:0] pk(input int q, input int r, input bit dz, input bit ov);
      logic [WIDTH-1:0] qq;
      logic [WIDTH-1:0] rr;
      qq = q[WIDTH-1:0];
      rr = r[WIDTH-1:0];
      return {qq, rr, dz, ov};
   endfunction

   // Reference behaviour from plain integer arithmetic.
   function automatic logic [RW-1:0] model(input int n, input int d);
      if (d == 0) return pk(MAXQ, n % (MAXQ + 1), 1'b1, 1'b0);
      if (n / d > MAXQ) return pk(MAXQ, 0, 1'b0, 1'b1);
      return pk(n / d, n % d, 1'b0, 1'b0);
   endfunction

   task automatic check(input string tag, input logic [RW-1:0] exp);
      logic [RW-1:0] got;
      got = {quotient, remainder, error_divide_by_zero, overflow};
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed q=%0d r=%0d dz=%0b ov=%0b, expected q=%0d r=%0d dz=%0b ov=%0b",
                tag, got[RW-1:WIDTH+2], got[WIDTH+1:2], got[1], got[0],
                exp[RW-1:WIDTH+2], exp[WIDTH+1:2], exp[1], exp[0]);
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due == cyc) begin
         e = pend.pop_front();
         check(e.tag, e.res);
         idle_zero = 1'b0;
         if (e.tag != "sweep")
            $display("TXN %s N=%0d D=%0d -> q=%0d r=%0d dz=%0b ov=%0b",
                     e.tag, e.n, e.d, quotient, remainder, error_divide_by_zero, overflow);
      end else if (idle_zero) begin
         check("idle_zero", '0);
      end
   endtask

   task automatic apply(input string tag, input int n, input int d, input logic [RW-1:0] exp);
      exp_t e;
      dividend = n[2*WIDTH-1:0];
      divisor  = d[WIDTH-1:0];
      e.due = cyc + LAT;
      e.tag = tag;
      e.n   = n;
      e.d   = d;
      e.res = exp;
      pend.push_back(e);
      tick();
   endtask

   initial begin
      dividend = 10'd219;
      divisor  = 5'd12;
      reset    = 1'b1;
      #1;
      check("reset_initial", '0);
      tick();
      tick();
      #3 reset = 1'b0;

      apply("normal_219_12",  219, 12, pk(18, 3,  1'b0, 1'b0));
      apply("normal_100_7",   100, 7,  pk(14, 2,  1'b0, 1'b0));
      apply("zero_0_1",       0,   1,  pk(0,  0,  1'b0, 1'b0));
      apply("max_991_31",     991, 31, pk(31, 30, 1'b0, 1'b0));
      apply("ovf_1023_31",    1023, 31, pk(31, 0, 1'b0, 1'b1));
      apply("ovf_64_2",       64,  2,  pk(31, 0,  1'b0, 1'b1));
      apply("dbz_37_0",       37,  0,  pk(31, 5,  1'b1, 1'b0));
      apply("dbz_1023_0",     1023, 0, pk(31, 31, 1'b1, 1'b0));
      apply("normal_30_1",    30,  1,  pk(30, 0,  1'b0, 1'b0));
      apply("ovf_32_1",       32,  1,  pk(31, 0,  1'b0, 1'b1));

      for (int d = 0; d <= MAXQ; d++) begin
         for (int n = 0; n < (1 << (2 * WIDTH)); n++) begin
            if (d == 13 && n == 500) begin
               #2 reset = 1'b1;
               #1;
               check("reset_midstream", '0);
               pend.delete();
               idle_zero = 1'b1;
               tick();
               tick();
               #3 reset = 1'b0;
            end
            apply("sweep", n, d, model(n, d));
         end
         $display("SWEEP D=%0d done checks=%0d failures=%0d", d, checks, failures);
      end

      repeat (LAT) tick();
      checks++;
      assert (pend.size() === 0) else begin
         failures++;
         $error("FAIL drain: observed %0d pending results, expected 0", pend.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
